// File: rtl/oldland_debug_host.sv
// Host-side initiator for the Oldland debug mailbox: writes cmd/addr/data into
// the shared mailbox RAM, handshakes dbg_req/dbg_ack and returns one response.
module oldland_debug_host #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TIMEOUT_BITS   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic [1:0]  dbg_addr,
  output logic [31:0] dbg_wdata,
  output logic        dbg_wr_en,
  input  logic [31:0] dbg_rdata,
  output logic        dbg_req,
  input  logic        dbg_ack
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_WR_CMD  = 4'd1;
  localparam logic [3:0] S_WR_ADDR = 4'd2;
  localparam logic [3:0] S_WR_DATA = 4'd3;
  localparam logic [3:0] S_REQ     = 4'd4;
  localparam logic [3:0] S_RD_ADDR = 4'd5;
  localparam logic [3:0] S_RD_CAP  = 4'd6;
  localparam logic [3:0] S_RELEASE = 4'd7;
  localparam logic [3:0] S_RESP    = 4'd8;

  localparam logic [3:0] CMD_READ_REG = 4'd3;
  localparam logic [TIMEOUT_BITS:0] TO_LIMIT = (TIMEOUT_BITS + 1)'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_BITS:0] CNT_ONE  = {{TIMEOUT_BITS{1'b0}}, 1'b1};

  logic [3:0]              state_q, state_d;
  logic [3:0]              cmd_q, cmd_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             data_q, data_d;
  logic [31:0]             result_q, result_d;
  logic                    timeout_q, timeout_d;
  logic                    req_q, req_d;
  logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;
  logic [TIMEOUT_BITS:0]   cnt_inc;
  logic                    expire;

  // One extra bit so the compare cannot alias when the counter is full.
  assign cnt_inc = {1'b0, cnt_q} + CNT_ONE;
  assign expire  = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIMIT);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_d     = cmd;
          addr_d    = cmd_addr;
          data_d    = cmd_data;
          timeout_d = 1'b0;
          state_d   = S_WR_CMD;
        end
      end
      S_WR_CMD:  state_d = S_WR_ADDR;
      S_WR_ADDR: state_d = S_WR_DATA;
      S_WR_DATA: begin
        cnt_d   = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        cnt_d = cnt_inc[TIMEOUT_BITS-1:0];
        // Ack has priority over a simultaneous expiry.
        if (dbg_ack) begin
          state_d = (cmd_q == CMD_READ_REG) ? S_RD_ADDR : S_RELEASE;
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = S_RELEASE;
        end
      end
      S_RD_ADDR: state_d = S_RD_CAP;
      S_RD_CAP: begin
        result_d = dbg_rdata;
        state_d  = S_RELEASE;
      end
      S_RELEASE: begin
        if (!dbg_ack) state_d = S_RESP;
      end
      S_RESP: begin
        timeout_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_d = (state_d == S_REQ) || (state_d == S_RD_ADDR) || (state_d == S_RD_CAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      req_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    dbg_addr  = 2'd0;
    dbg_wdata = 32'd0;
    dbg_wr_en = 1'b0;
    case (state_q)
      S_WR_CMD: begin
        dbg_wr_en = 1'b1;
        dbg_addr  = 2'd0;
        dbg_wdata = {28'd0, cmd_q};
      end
      S_WR_ADDR: begin
        dbg_wr_en = 1'b1;
        dbg_addr  = 2'd1;
        dbg_wdata = addr_q;
      end
      S_WR_DATA: begin
        dbg_wr_en = 1'b1;
        dbg_addr  = 2'd2;
        dbg_wdata = data_q;
      end
      S_RD_ADDR: dbg_addr = 2'd3;
      default: ;
    endcase
  end

  // Holding off while ack is high drains a stale ack left over from a reset.
  assign cmd_ready   = (state_q == S_IDLE) && !dbg_ack;
  assign dbg_req     = req_q;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_timeout = rsp_valid && timeout_q;
  assign rsp_data    = (rsp_valid && (cmd_q == CMD_READ_REG) && !timeout_q) ? result_q : 32'd0;

endmodule

// File: tb/tb_oldland_debug_host.sv
// Directed bench for oldland_debug_host with a small mailbox RAM model on port A.
module tb_oldland_debug_host;

  localparam logic [31:0] RESULT_WORD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic [1:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_wr_en;
  logic [31:0] dbg_rdata;
  logic        dbg_req;
  logic        dbg_ack;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mb0, mb1, mb2;
  logic        wr3_seen;

  oldland_debug_host #(.TIMEOUT_CYCLES(20), .TIMEOUT_BITS(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_wr_en(dbg_wr_en),
    .dbg_rdata(dbg_rdata), .dbg_req(dbg_req), .dbg_ack(dbg_ack)
  );

  always #5 clk = ~clk;

  // Mailbox port A: words 0..2 are writable, word 3 holds the CPU result.
  always @(posedge clk) begin
    if (rst) begin
      wr3_seen <= 1'b0;
    end else if (dbg_wr_en) begin
      case (dbg_addr)
        2'd0: mb0 <= dbg_wdata;
        2'd1: mb1 <= dbg_wdata;
        2'd2: mb2 <= dbg_wdata;
        default: wr3_seen <= 1'b1;
      endcase
    end
    case (dbg_addr)
      2'd0: dbg_rdata <= mb0;
      2'd1: dbg_rdata <= mb1;
      2'd2: dbg_rdata <= mb2;
      default: dbg_rdata <= RESULT_WORD;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Offers one command in cycle 0; returns in cycle 1 with cmd_valid dropped.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd = c;
    cmd_addr = a;
    cmd_data = d;
    #1;
    chk1("issue_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    int rsps;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd = 4'd0;
    cmd_addr = 32'd0;
    cmd_data = 32'd0;
    dbg_ack = 1'b0;
    tick(); tick(); tick();
    chk1("rst_req", dbg_req, 1'b0);
    chk1("rst_wr_en", dbg_wr_en, 1'b0);
    chk("rst_addr", {30'd0, dbg_addr}, 32'd0);
    chk("rst_wdata", dbg_wdata, 32'd0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk1("rst_rsp_timeout", rsp_timeout, 1'b0);
    rst = 1'b0;
    tick();
    chk1("idle_ready", cmd_ready, 1'b1);

    // RUN, ack in cycle 6, dropped in cycle 9.
    issue(4'd1, 32'h1234_5678, 32'hCAFE_0001);
    chk1("run_c1_we", dbg_wr_en, 1'b1);
    chk("run_c1_addr", {30'd0, dbg_addr}, 32'd0);
    chk("run_c1_wdata", dbg_wdata, 32'd1);
    chk1("run_c1_ready", cmd_ready, 1'b0);
    tick();
    chk("run_c2_addr", {30'd0, dbg_addr}, 32'd1);
    chk("run_c2_wdata", dbg_wdata, 32'h1234_5678);
    tick();
    chk("run_c3_addr", {30'd0, dbg_addr}, 32'd2);
    chk("run_c3_wdata", dbg_wdata, 32'hCAFE_0001);
    chk1("run_c3_req", dbg_req, 1'b0);
    tick();
    chk1("run_c4_req", dbg_req, 1'b1);
    chk1("run_c4_we", dbg_wr_en, 1'b0);
    tick();
    chk1("run_c5_req", dbg_req, 1'b1);
    tick();
    chk1("run_c6_req", dbg_req, 1'b1);
    dbg_ack = 1'b1;
    tick();
    chk1("run_c7_req", dbg_req, 1'b0);
    tick();
    chk1("run_c8_rsp", rsp_valid, 1'b0);
    tick();
    chk1("run_c9_rsp", rsp_valid, 1'b0);
    dbg_ack = 1'b0;
    tick();
    chk1("run_c10_rsp", rsp_valid, 1'b1);
    chk("run_c10_data", rsp_data, 32'd0);
    chk1("run_c10_to", rsp_timeout, 1'b0);
    tick();
    chk1("run_c11_rsp", rsp_valid, 1'b0);
    chk1("run_c11_ready", cmd_ready, 1'b1);
    chk("run_mb0", mb0, 32'd1);
    chk("run_mb1", mb1, 32'h1234_5678);
    chk("run_mb2", mb2, 32'hCAFE_0001);

    // READ_REG of the PC, ack in cycle 5.
    issue(4'd3, 32'd8, 32'd0);
    tick(); tick(); tick();
    tick();
    dbg_ack = 1'b1;
    tick();
    chk("rd_c6_addr", {30'd0, dbg_addr}, 32'd3);
    chk1("rd_c6_req", dbg_req, 1'b1);
    chk1("rd_c6_we", dbg_wr_en, 1'b0);
    tick();
    chk1("rd_c7_req", dbg_req, 1'b1);
    tick();
    chk1("rd_c8_req", dbg_req, 1'b0);
    dbg_ack = 1'b0;
    tick();
    chk1("rd_c9_rsp", rsp_valid, 1'b1);
    chk("rd_c9_data", rsp_data, RESULT_WORD);
    chk1("rd_c9_to", rsp_timeout, 1'b0);
    chk("rd_mb1", mb1, 32'd8);
    chk1("rd_word3_untouched", wr3_seen, 1'b0);
    tick();

    // HALT with no ack: request held for exactly 20 cycles, then timeout.
    issue(4'd0, 32'd0, 32'd0);
    tick(); tick(); tick();
    n = 0;
    while (dbg_req && n < 100) begin
      n++;
      tick();
    end
    chk("to_req_cycles", n, 32'd20);
    tick();
    chk1("to_rsp", rsp_valid, 1'b1);
    chk1("to_flag", rsp_timeout, 1'b1);
    chk("to_data", rsp_data, 32'd0);
    tick();
    chk1("to_after_rsp", rsp_valid, 1'b0);

    // Ack arrives in the very cycle the timeout would expire.
    issue(4'd1, 32'd0, 32'd0);
    tick(); tick(); tick();
    repeat (19) tick();
    chk1("race_c23_req", dbg_req, 1'b1);
    dbg_ack = 1'b1;
    tick();
    chk1("race_c24_req", dbg_req, 1'b0);
    dbg_ack = 1'b0;
    tick();
    chk1("race_rsp", rsp_valid, 1'b1);
    chk1("race_to", rsp_timeout, 1'b0);
    tick();

    // Reset pulsed in REQ with ack high.
    issue(4'd1, 32'd0, 32'd0);
    tick(); tick(); tick();
    tick();
    dbg_ack = 1'b1;
    rst = 1'b1;
    tick();
    chk1("rst_mid_req", dbg_req, 1'b0);
    chk1("rst_mid_ready", cmd_ready, 1'b0);
    chk1("rst_mid_rsp", rsp_valid, 1'b0);
    rst = 1'b0;
    tick();
    chk1("rst_drain_ready", cmd_ready, 1'b0);
    chk1("rst_drain_rsp", rsp_valid, 1'b0);
    tick();
    dbg_ack = 1'b0;
    #1;
    chk1("rst_drained_ready", cmd_ready, 1'b1);
    chk1("rst_drained_rsp", rsp_valid, 1'b0);
    tick();

    // Back-to-back STEP with cmd_valid held and an immediate responder.
    acc = 0;
    rsps = 0;
    cmd = 4'd2;
    cmd_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (k == 30) cmd_valid = 1'b0;
      #1;
      if (rsp_valid) rsps++;
      if (cmd_valid && cmd_ready) begin
        chk("b2b_order", acc, rsps);
        acc++;
      end
      dbg_ack = dbg_req;
      tick();
    end
    chk("b2b_accepts", acc, 32'd5);
    chk("b2b_responses", rsps, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
